fib_req_scheduler: RTL and testbench
====================================

Name: fib_req_scheduler

Overview:
- Shares one Fibonacci adder datapath between NUM_REQ requesters; each request asks for term F(n) of the sequence F0=1, F1=1, Fn=Fn-1+Fn-2.
- A round-robin arbiter accepts one request at a time, and an FSM iterates the adder one term per cycle.
- The result is returned on a valid/ready response port tagged with the requester id, with an overflow flag.
- Sits between software-visible requesters and the sequence-generator datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, width of Fibonacci terms and result.
- IDX_WIDTH, 6, width of requested term index n.
- ID_WIDTH, 2, width of requester id; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_index  in  NUM_REQ*IDX_WIDTH  packed term indices; requester i uses slice [i*IDX_WIDTH +: IDX_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  ID_WIDTH  requester index of the result.
- rsp_data  out  DATA_WIDTH  F(n) mod 2^DATA_WIDTH.
- rsp_overflow  out  1  any addition for this result carried out of DATA_WIDTH.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async, resetn=0): state=IDLE, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_overflow=0, busy=0, req_ready=0. Internal registers a=0, b=0, cnt=0.
- Reset mid-CALC or mid-DONE aborts the operation; the pending result is discarded and never presented.
- Registers a and b hold consecutive terms; cnt counts the remaining steps.
- States:
  - IDLE: req_ready is combinational. It is one-hot on the first requester with req_valid, searching from the rr pointer upward with wrap. It is all zero if no request is valid or state!=IDLE.
  - On accept of requester g: a<=1, b<=1, cnt<=req_index[g], rsp_id<=g, ovf<=0, rr pointer<=(g+1) mod NUM_REQ, go to CALC.
  - CALC: if cnt<=1, then rsp_data<=b, rsp_overflow<=ovf, rsp_valid<=1, go to DONE. Otherwise a<=b, b<=a+b (truncated), ovf<=ovf | carry-out, cnt<=cnt-1.
  - DONE: hold rsp_* stable while rsp_valid & !rsp_ready. On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE. No request is accepted in the same cycle (one bubble cycle minimum between results).
- Latency: rsp_valid rises max(n,1) clock edges after the accept edge. For n=0 or n=1 that is 1 cycle and rsp_data=1.
- Throughput: one request in flight. Requesters must hold req_valid and req_index stable until accepted. Behaviour is undefined if a requester drops req_valid before acceptance.
- Fairness: a requester with continuous req_valid is served within NUM_REQ grants.
- Arithmetic: all terms are computed mod 2^DATA_WIDTH. Overflow is sticky per request and cleared on accept.
  - DATA_WIDTH=32: F(46)=2971215073 is the last term without overflow; F(47) sets rsp_overflow.
- Maximum index 2^IDX_WIDTH-1 is legal; the result wraps with rsp_overflow=1 as applicable.
- Simultaneous requests are resolved only by the rr pointer; index values do not affect priority.
- rsp_id, rsp_data and rsp_overflow retain their last values after handshake until the next result is loaded.

Test Plan:
- Reset, then single request req0 index=5 -> accepted on the first edge; rsp_valid exactly 5 cycles later with rsp_data=8, rsp_id=0, rsp_overflow=0. Indices 0, 1, 2 -> rsp_data 1, 1, 2 with latency 1, 1, 2.
- All four requesters valid continuously, indices 3/4/6/7 -> grants in order 0,1,2,3,0...; rsp_data 3, 5, 13, 21 with matching rsp_id.
- DATA_WIDTH=8: index 12 -> rsp_data=233, rsp_overflow=0. Index 13 -> rsp_data=121, rsp_overflow=1. Next request index 2 -> rsp_overflow=0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready all 0, busy=1. rsp_ready=1 -> handshake; next grant occurs no earlier than the following cycle.
- Assert resetn=0 asynchronously mid-CALC of index 40 -> outputs return to reset values immediately. After release, the pending requester is regranted from pointer 0 and the result is correct.
- Requester 2 alone valid with pointer at 3 -> wrap-around search grants 2 and the pointer becomes 3.

Source files
------------

// File: rtl/fib_req_scheduler.sv
// Round-robin scheduler sharing one Fibonacci adder between NUM_REQ requesters.
// Returns F(n) (F0=F1=1) tagged with requester id and a sticky overflow flag.
module fib_req_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 6,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*IDX_WIDTH-1:0]   req_index,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_overflow,
    output logic                           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_q, rr_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_ovf_q, rsp_ovf_d;

    logic                   grant_vld_c;
    logic [ID_WIDTH-1:0]    grant_id_c;
    logic [NUM_REQ-1:0]     grant_c;
    logic [IDX_WIDTH-1:0]   grant_idx_c;
    logic [DATA_WIDTH:0]    sum_c;

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin : arb
        logic [ID_WIDTH:0]   pos;
        logic [ID_WIDTH-1:0] idx;
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        grant_c     = '0;
        grant_idx_c = '0;
        pos         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_q} + (ID_WIDTH+1)'(k);
            if (pos >= (ID_WIDTH+1)'(NUM_REQ)) begin
                pos = pos - (ID_WIDTH+1)'(NUM_REQ);
            end
            idx = ID_WIDTH'(pos);
            if (!grant_vld_c && req_valid[idx]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = idx;
            end
        end
        if (state_q != IDLE || !resetn) begin
            grant_vld_c = 1'b0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_vld_c && grant_id_c == ID_WIDTH'(k)) begin
                grant_c[k]  = 1'b1;
                grant_idx_c = req_index[k*IDX_WIDTH +: IDX_WIDTH];
            end
        end
    end

    assign sum_c = {1'b0, a_q} + {1'b0, b_q};

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        case (state_q)
            IDLE: begin
                if (grant_vld_c) begin
                    a_d      = DATA_WIDTH'(1);
                    b_d      = DATA_WIDTH'(1);
                    cnt_d    = grant_idx_c;
                    rsp_id_d = grant_id_c;
                    ovf_d    = 1'b0;
                    rr_d     = (grant_id_c == ID_WIDTH'(NUM_REQ-1)) ? '0
                                                                    : grant_id_c + ID_WIDTH'(1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q <= IDX_WIDTH'(1)) begin
                    rsp_data_d  = b_q;
                    rsp_ovf_d   = ovf_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    a_d   = b_q;
                    b_d   = sum_c[DATA_WIDTH-1:0];
                    ovf_d = ovf_q | sum_c[DATA_WIDTH];
                    cnt_d = cnt_q - IDX_WIDTH'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign req_ready    = grant_c;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_overflow = rsp_ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fib_req_scheduler.sv
// Bench for fib_req_scheduler: 32-bit and 8-bit instances share stimulus and are
// checked every cycle against a transaction-level model plus literal expectations.
module tb_fib_req_scheduler;

    localparam int NR = 4;
    localparam int IW = 6;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NR-1:0]   req_valid;
    logic [NR*IW-1:0] req_index;
    logic            rsp_ready;

    logic [NR-1:0]   req_ready, req_ready8;
    logic            rsp_valid, rsp_valid8, rsp_overflow, rsp_overflow8, busy, busy8;
    logic [1:0]      rsp_id, rsp_id8;
    logic [31:0]     rsp_data;
    logic [7:0]      rsp_data8;

    int n_cmp = 0;
    int n_err = 0;

    fib_req_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .IDX_WIDTH(6), .ID_WIDTH(2)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_index(req_index),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .busy(busy));

    fib_req_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .IDX_WIDTH(6), .ID_WIDTH(2)) dut8 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_index(req_index),
        .req_ready(req_ready8), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id8), .rsp_data(rsp_data8), .rsp_overflow(rsp_overflow8), .busy(busy8));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // F(n) mod 2^w with F0=F1=1, and whether any addition carried out of w bits.
    function automatic void fib(input int n, input int w, output longint v, output bit o);
        longint a = 1;
        longint b = 1;
        longint s;
        longint m = longint'(1) << w;
        o = 1'b0;
        for (int i = 2; i <= n; i++) begin
            s = a + b;
            if (s >= m) begin
                o = 1'b1;
                s = s - m;
            end
            a = b;
            b = s;
        end
        v = b;
    endfunction

    // Transaction-level model state.
    bit     m_busy = 0, m_valid = 0, m_o32 = 0, m_o8 = 0;
    int     m_ptr = 0, m_cnt = 0, m_id = 0, m_n = 0;
    longint m_d32 = 0, m_d8 = 0;

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g = '0;
        if (resetn !== 1'b1 || m_busy) return g;
        for (int k = 0; k < NR; k++) begin
            int r = (m_ptr + k) % NR;
            if (req_valid[r] === 1'b1) begin
                g[r] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_valid = 0; m_ptr = 0; m_cnt = 0; m_id = 0;
            m_d32 = 0; m_o32 = 0; m_d8 = 0; m_o8 = 0;
        end else if (!m_busy) begin
            logic [NR-1:0] g;
            g = model_grant();
            for (int k = 0; k < NR; k++) begin
                if (g[k]) begin
                    m_busy = 1;
                    m_id   = k;
                    m_n    = int'(req_index[k*IW +: IW]);
                    m_cnt  = (m_n < 1) ? 1 : m_n;
                    m_ptr  = (k + 1) % NR;
                end
            end
        end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                fib(m_n, 32, m_d32, m_o32);
                fib(m_n, 8, m_d8, m_o8);
            end
        end else if (rsp_ready) begin
            m_valid = 0;
            m_busy  = 0;
        end
    end

    always @(negedge clk) begin
        check("req_ready", 64'(req_ready), 64'(model_grant()));
        check("req_ready8", 64'(req_ready8), 64'(model_grant()));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_valid8", 64'(rsp_valid8), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_busy));
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_data", 64'(rsp_data), 64'(m_d32));
        check("rsp_overflow", 64'(rsp_overflow), 64'(m_o32));
        check("rsp_data8", 64'(rsp_data8), 64'(m_d8));
        check("rsp_overflow8", 64'(rsp_overflow8), 64'(m_o8));
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid && lat < 300);
        if (!rsp_valid) check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
    endtask

    task automatic single(input int id, input int n, input int lat_exp,
                          input logic [63:0] d32, input logic [63:0] o32,
                          input logic [63:0] d8, input logic [63:0] o8);
        int lat;
        @(posedge clk); #2;
        req_valid[id] = 1'b1;
        req_index[id*IW +: IW] = IW'(n);
        @(negedge clk);
        check("grant_onehot", 64'(req_ready), 64'(1) << id);
        @(posedge clk); #2;
        req_valid[id] = 1'b0;
        wait_valid(lat);
        check("latency", 64'(lat), 64'(lat_exp));
        check("lit_data", 64'(rsp_data), d32);
        check("lit_ovf", 64'(rsp_overflow), o32);
        check("lit_data8", 64'(rsp_data8), d8);
        check("lit_ovf8", 64'(rsp_overflow8), o8);
        check("lit_id", 64'(rsp_id), 64'(id));
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2 resetn = 1'b0;
        @(posedge clk); #2 resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     lat, got, cyc;
        longint v;
        bit     o;
        int     exp_ids[5] = '{0, 1, 2, 3, 0};
        int     exp_dat[5] = '{3, 5, 13, 21, 3};

        resetn = 1'b0; req_valid = '0; req_index = '0; rsp_ready = 1'b1;

        // Pin the model against hand-computed values.
        fib(5, 32, v, o);  check("model_f5", 64'(v), 64'd8);
        fib(46, 32, v, o); check("model_f46", 64'(v), 64'd2971215073); check("model_f46_ovf", 64'(o), 64'd0);
        fib(47, 32, v, o); check("model_f47_ovf", 64'(o), 64'd1);
        fib(13, 8, v, o);  check("model_f13_8", 64'(v), 64'd121);  check("model_f13_8_ovf", 64'(o), 64'd1);

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        @(posedge clk); #2 resetn = 1'b1;

        // Basic terms and latency, including n=0/1.
        single(0, 5, 5, 64'd8, 0, 64'd8, 0);
        single(0, 0, 1, 64'd1, 0, 64'd1, 0);
        single(0, 1, 1, 64'd1, 0, 64'd1, 0);
        single(0, 2, 2, 64'd2, 0, 64'd2, 0);

        // Overflow boundaries for both widths; flag cleared on the next request.
        single(1, 12, 12, 64'd233, 0, 64'd233, 0);
        single(1, 13, 13, 64'd377, 0, 64'd121, 1);
        single(1, 2, 2, 64'd2, 0, 64'd2, 0);
        single(1, 46, 46, 64'd2971215073, 0, 64'd225, 1);
        single(1, 47, 47, 64'd512559680, 1, 64'd64, 1);
        begin
            longint v8; bit o8;
            fib(63, 32, v, o); fib(63, 8, v8, o8);
            single(2, 63, 63, 64'(v), 64'(o), 64'(v8), 64'(o8));
        end

        // All four requesters continuously valid from pointer 0.
        reset_pulse();
        @(posedge clk); #2;
        req_valid = 4'b1111;
        req_index = {6'd7, 6'd6, 6'd4, 6'd3};
        got = 0; cyc = 0;
        while (got < 5 && cyc < 500) begin
            @(negedge clk); cyc++;
            if (rsp_valid) begin
                check("rr_id", 64'(rsp_id), 64'(exp_ids[got]));
                check("rr_data", 64'(rsp_data), 64'(exp_dat[got]));
                got++;
            end
        end
        check("rr_count", 64'(got), 64'd5);
        @(posedge clk); #2 req_valid = '0;
        repeat (3) @(posedge clk);

        // Backpressure: result held, nothing accepted, then a one-cycle bubble.
        #2 rsp_ready = 1'b0;
        req_valid[0] = 1'b1; req_index[0 +: IW] = 6'd3;
        @(posedge clk); #2 req_valid[0] = 1'b0;
        req_valid[2] = 1'b1; req_index[2*IW +: IW] = 6'd1;
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_data", 64'(rsp_data), 64'd3);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bubble_valid", 64'(rsp_valid), 64'd0);
        check("bubble_busy", 64'(busy), 64'd0);
        check("bubble_grant", 64'(req_ready), 64'b0100);
        @(posedge clk); #2 req_valid[2] = 1'b0;
        wait_valid(lat);
        check("bp_next_id", 64'(rsp_id), 64'd2);

        // Pointer is now 3: requester 2 alone wraps, pointer stays 3.
        single(2, 2, 2, 64'd2, 0, 64'd2, 0);
        @(posedge clk); #2;
        req_valid = 4'b1001; req_index[0 +: IW] = 6'd1; req_index[3*IW +: IW] = 6'd1;
        @(negedge clk);
        check("wrap_grant", 64'(req_ready), 64'b1000);
        @(posedge clk); #2 req_valid[3] = 1'b0;
        wait_valid(lat);
        check("wrap_id", 64'(rsp_id), 64'd3);
        wait_valid(lat);
        req_valid[0] = 1'b0;
        check("wrap_next_id", 64'(rsp_id), 64'd0);

        // Async reset mid-calculation; pointer restarts at 0.
        @(posedge clk); #2;
        req_valid[1] = 1'b1; req_index[1*IW +: IW] = 6'd40;
        @(negedge clk);
        check("pre_rst_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #2;
        req_valid[3] = 1'b1; req_index[3*IW +: IW] = 6'd2;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        check("arst_data", 64'(rsp_data), 64'd0);
        check("arst_id", 64'(rsp_id), 64'd0);
        check("arst_ovf", 64'(rsp_overflow), 64'd0);
        @(posedge clk); #2 resetn = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #2 req_valid[1] = 1'b0;
        wait_valid(lat);
        check("f40_latency", 64'(lat), 64'd40);
        check("f40_data", 64'(rsp_data), 64'd165580141);
        check("f40_id", 64'(rsp_id), 64'd1);
        wait_valid(lat);
        req_valid[3] = 1'b0;
        check("after_rst_id", 64'(rsp_id), 64'd3);
        check("after_rst_data", 64'(rsp_data), 64'd2);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
